spi_sub: RTL and testbench

//  SPI subordinate (slave) endpoint; the far end of the spi_main link. Oversamples i_sclk/i_cs_n/i_mosi
//  in the i_clk domain, supports all four CPOL/CPHA modes, shifts LSB first (bit 0 first). Exposes a
//  one-byte TX buffer with valid/ready load and an RX byte output with a one-cycle valid pulse.

---
 rtl/spi_sub_pkg.sv | 20 ++
 rtl/spi_sub_if.sv | 38 +++
 rtl/spi_sub_sync_edge.sv | 31 +++
 rtl/spi_sub.sv | 193 +++++++++++++++++++
 tb/tb_spi_sub.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_sub_pkg.sv
// Shared constants and FSM encoding for the SPI subordinate endpoint.
// Optional feature macro used by the slice: SPI_SUB_UNDERRUN_EN.
package spi_sub_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    localparam logic [7:0] IDLE_FILL = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spiState_e;

endpackage

// File: rtl/spi_sub_if.sv
// Bus and byte-stream signals of the SPI subordinate, grouped with master/slave views.
// SPI_SUB_UNDERRUN_EN adds the sticky o_tx_underrun flag.
interface spi_sub_if #(
    parameter int DATA_W = 8
);

    logic [1:0]        i_mode;
    logic              i_sclk;
    logic              i_cs_n;
    logic              i_mosi;
    logic              o_miso;
    logic [DATA_W-1:0] i_tx_byte;
    logic              i_tx_valid;
    logic              o_tx_ready;
    logic [DATA_W-1:0] o_rx_byte;
    logic              o_rx_valid;
    logic              o_busy;
`ifdef SPI_SUB_UNDERRUN_EN
    logic              o_tx_underrun;
`endif

    modport slave (
        input  i_mode, i_sclk, i_cs_n, i_mosi, i_tx_byte, i_tx_valid,
        output o_miso, o_tx_ready, o_rx_byte, o_rx_valid, o_busy
`ifdef SPI_SUB_UNDERRUN_EN
        , output o_tx_underrun
`endif
    );

    modport master (
        output i_mode, i_sclk, i_cs_n, i_mosi, i_tx_byte, i_tx_valid,
        input  o_miso, o_tx_ready, o_rx_byte, o_rx_valid, o_busy
`ifdef SPI_SUB_UNDERRUN_EN
        , input o_tx_underrun
`endif
    );

endinterface

// File: rtl/spi_sub_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line with single-cycle rise/fall pulses.
module spi_sub_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    // Reset to low so a chip select already held low never looks like a fresh fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_o = level & ~prev_q;
    assign fall_o = ~level & prev_q;

endmodule

// File: rtl/spi_sub.sv
// SPI subordinate: oversampled SCLK/CS_n/MOSI, all four modes, LSB first, one-word TX buffer.
// Define SPI_SUB_UNDERRUN_EN to add the sticky o_tx_underrun output.
module spi_sub
    import spi_sub_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    spi_sub_if.slave bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic sclkRise, sclkFall, csRise, csFall;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic mosiLevel;

    spiState_e         state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] txBuf_q, txBuf_d;
    logic              txFull_q, txFull_d;
    logic [DATA_W-1:0] txShift_q, txShift_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] rxShift_q, rxShift_d;
    logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
    logic [DATA_W-1:0] rxByte_q, rxByte_d;
    logic              rxValid_q, rxValid_d;

    logic [1:0]        activeMode;
    logic              leadEdge, trailEdge, sampleEdge, advanceEdge;
    logic              txAccept, consume;
    logic [DATA_W-1:0] nextWord;

    spi_sub_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSclkSync (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .async_i(bus.i_sclk),
        .rise_o (sclkRise),
        .fall_o (sclkFall)
    );

    spi_sub_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uCsSync (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .async_i(bus.i_cs_n),
        .rise_o (csRise),
        .fall_o (csFall)
    );

    // MOSI gets the same depth as SCLK so a detected edge lines up with its data bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mosiSync_q <= '0;
        end else begin
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], bus.i_mosi};
        end
    end

    assign mosiLevel = mosiSync_q[SYNC_STAGES-1];
    assign nextWord  = txFull_q ? txBuf_q : {DATA_W{IDLE_FILL[0]}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE0;
            txBuf_q   <= '0;
            txFull_q  <= 1'b0;
            txShift_q <= '0;
            miso_q    <= 1'b0;
            rxShift_q <= '0;
            bitCnt_q  <= '0;
            rxByte_q  <= '0;
            rxValid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            txBuf_q   <= txBuf_d;
            txFull_q  <= txFull_d;
            txShift_q <= txShift_d;
            miso_q    <= miso_d;
            rxShift_q <= rxShift_d;
            bitCnt_q  <= bitCnt_d;
            rxByte_q  <= rxByte_d;
            rxValid_q <= rxValid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        txBuf_d   = txBuf_q;
        txFull_d  = txFull_q;
        txShift_d = txShift_q;
        miso_d    = miso_q;
        rxShift_d = rxShift_q;
        bitCnt_d  = bitCnt_q;
        rxByte_d  = rxByte_q;
        rxValid_d = 1'b0;
        consume   = 1'b0;

        // The mode that will govern this frame is the live input until CS_n falls.
        activeMode  = (state_q == ST_IDLE) ? bus.i_mode : mode_q;
        leadEdge    = activeMode[CPOL_BIT] ? sclkFall : sclkRise;
        trailEdge   = activeMode[CPOL_BIT] ? sclkRise : sclkFall;
        sampleEdge  = activeMode[CPHA_BIT] ? trailEdge : leadEdge;
        advanceEdge = activeMode[CPHA_BIT] ? leadEdge : trailEdge;
        txAccept    = bus.i_tx_valid & ~txFull_q;

        case (state_q)
            ST_IDLE: begin
                mode_d = bus.i_mode;
                miso_d = 1'b0;
                if (csFall) begin
                    state_d  = ST_ACTIVE;
                    consume  = 1'b1;
                    bitCnt_d = '0;
                    if (activeMode[CPHA_BIT]) begin
                        txShift_d = nextWord;
                    end else begin
                        miso_d    = nextWord[0];
                        txShift_d = nextWord >> 1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (csRise) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else begin
                    if (advanceEdge) begin
                        miso_d    = txShift_q[0];
                        txShift_d = txShift_q >> 1;
                    end
                    if (sampleEdge) begin
                        rxShift_d[bitCnt_q] = mosiLevel;
                        if (bitCnt_q == CNT_W'(DATA_W - 1)) begin
                            // Reloading the full word here works for both CPHA values:
                            // the next advance edge presents bit 0 of the new word.
                            rxByte_d  = rxShift_d;
                            rxValid_d = 1'b1;
                            bitCnt_d  = '0;
                            txShift_d = nextWord;
                            consume   = 1'b1;
                        end else begin
                            bitCnt_d = bitCnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (txAccept) begin
            txBuf_d  = bus.i_tx_byte;
            txFull_d = 1'b1;
        end else if (consume) begin
            txFull_d = 1'b0;
        end
    end

`ifdef SPI_SUB_UNDERRUN_EN
    logic underrun_q, underrun_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    // A word starting on an empty buffer wins over a load in the same cycle.
    always_comb begin
        underrun_d = underrun_q;
        if (consume && !txFull_q) begin
            underrun_d = 1'b1;
        end else if (txAccept) begin
            underrun_d = 1'b0;
        end
    end

    assign bus.o_tx_underrun = underrun_q;
`endif

    assign bus.o_miso     = miso_q;
    assign bus.o_tx_ready = ~txFull_q;
    assign bus.o_rx_byte  = rxByte_q;
    assign bus.o_rx_valid = rxValid_q;
    assign bus.o_busy     = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_sub.sv
// Directed bench for spi_sub: table-driven mode sweep plus back-to-back, abort, reset and underrun sequences.
module tb_spi_sub;
    import spi_sub_pkg::*;

    localparam int HALF_SCLK = 8;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] txByte;
        logic [7:0] mosiByte;
        logic       flipMode;
        logic [7:0] expMiso;
        logic [7:0] expRx;
    } vector_t;

    logic clk;
    logic rstN;
    int   checks;
    int   errors;
    int   validCycles;
    int   rxRises;
    logic prevValid;
    logic [7:0] rxLog[$];
    vector_t vecs[5];

    spi_sub_if #(.DATA_W(8)) bus();

    spi_sub #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .i_clk  (clk),
        .i_rst_n(rstN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rx_valid high cycles and rising edges separately so a stretched pulse shows up.
    always @(negedge clk) begin
        if (bus.o_rx_valid) begin
            validCycles++;
            rxLog.push_back(bus.o_rx_byte);
        end
        if (bus.o_rx_valid && !prevValid) rxRises++;
        prevValid = bus.o_rx_valid;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic loadTx(input logic [7:0] b);
        int waited;
        waited = 0;
        while (!bus.o_tx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("loadReady", {31'd0, bus.o_tx_ready}, 32'd1);
        bus.i_tx_byte  = b;
        bus.i_tx_valid = 1'b1;
        @(negedge clk);
        bus.i_tx_valid = 1'b0;
    endtask

    task automatic pulseValid(input logic [7:0] b);
        bus.i_tx_byte  = b;
        bus.i_tx_valid = 1'b1;
        @(negedge clk);
        bus.i_tx_valid = 1'b0;
    endtask

    task automatic csDown(input logic [1:0] mode);
        bus.i_mode = mode;
        bus.i_sclk = mode[CPOL_BIT];
        cycles(6);
        bus.i_cs_n = 1'b0;
        cycles(8);
    endtask

    task automatic csUp();
        cycles(8);
        bus.i_cs_n = 1'b1;
        cycles(8);
    endtask

    task automatic spiBits(input logic [1:0] mode, input int nBits,
                           input logic [15:0] mosiData, output logic [15:0] misoData);
        logic pol;
        logic pha;
        pol = mode[CPOL_BIT];
        pha = mode[CPHA_BIT];
        misoData = '0;
        for (int i = 0; i < nBits; i++) begin
            if (!pha) begin
                bus.i_mosi = mosiData[i];
                cycles(HALF_SCLK);
                bus.i_sclk  = ~pol;
                misoData[i] = bus.o_miso;
                cycles(HALF_SCLK);
                bus.i_sclk  = pol;
            end else begin
                bus.i_sclk = ~pol;
                bus.i_mosi = mosiData[i];
                cycles(HALF_SCLK);
                bus.i_sclk  = pol;
                misoData[i] = bus.o_miso;
                cycles(HALF_SCLK);
            end
        end
    endtask

    task automatic applyStimulus(input vector_t v, input string tag);
        logic [15:0] miso;
        int r0;
        int v0;
        r0 = rxRises;
        v0 = validCycles;
        loadTx(v.txByte);
        csDown(v.mode);
        checkOutput({tag, ".busy"}, {31'd0, bus.o_busy}, 32'd1);
        checkOutput({tag, ".readyAfterFall"}, {31'd0, bus.o_tx_ready}, 32'd1);
        if (v.flipMode) bus.i_mode = ~v.mode;
        spiBits(v.mode, 8, {8'h00, v.mosiByte}, miso);
        csUp();
        checkOutput({tag, ".miso"}, {24'd0, miso[7:0]}, {24'd0, v.expMiso});
        checkOutput({tag, ".rxByte"}, {24'd0, bus.o_rx_byte}, {24'd0, v.expRx});
        checkOutput({tag, ".rxPulses"}, rxRises - r0, 32'd1);
        checkOutput({tag, ".rxWidth"}, validCycles - v0, 32'd1);
        checkOutput({tag, ".idleBusy"}, {31'd0, bus.o_busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] miso;
        int r0;
        int v0;
        int base;

        checks      = 0;
        errors      = 0;
        validCycles = 0;
        rxRises     = 0;
        prevValid   = 1'b0;

        vecs[0] = '{mode: MODE0, txByte: 8'hA5, mosiByte: 8'h3C, flipMode: 1'b0, expMiso: 8'hA5, expRx: 8'h3C};
        vecs[1] = '{mode: MODE1, txByte: 8'h5A, mosiByte: 8'hC3, flipMode: 1'b1, expMiso: 8'h5A, expRx: 8'hC3};
        vecs[2] = '{mode: MODE2, txByte: 8'hC3, mosiByte: 8'h5A, flipMode: 1'b1, expMiso: 8'hC3, expRx: 8'h5A};
        vecs[3] = '{mode: MODE3, txByte: 8'h96, mosiByte: 8'h69, flipMode: 1'b1, expMiso: 8'h96, expRx: 8'h69};
        vecs[4] = '{mode: MODE0, txByte: 8'h00, mosiByte: 8'hFF, flipMode: 1'b1, expMiso: 8'h00, expRx: 8'hFF};

        rstN           = 1'b0;
        bus.i_mode     = MODE0;
        bus.i_sclk     = 1'b0;
        bus.i_cs_n     = 1'b1;
        bus.i_mosi     = 1'b0;
        bus.i_tx_byte  = '0;
        bus.i_tx_valid = 1'b0;
        cycles(3);
        checkOutput("reset.miso", {31'd0, bus.o_miso}, 32'd0);
        checkOutput("reset.ready", {31'd0, bus.o_tx_ready}, 32'd1);
        checkOutput("reset.rxByte", {24'd0, bus.o_rx_byte}, 32'd0);
        checkOutput("reset.rxValid", {31'd0, bus.o_rx_valid}, 32'd0);
        checkOutput("reset.busy", {31'd0, bus.o_busy}, 32'd0);
`ifdef SPI_SUB_UNDERRUN_EN
        checkOutput("reset.underrun", {31'd0, bus.o_tx_underrun}, 32'd0);
`endif
        rstN = 1'b1;
        cycles(6);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back words under one CS_n; a load while full must not overwrite.
        loadTx(8'h11);
        pulseValid(8'h99);
        checkOutput("b2b.readyFull", {31'd0, bus.o_tx_ready}, 32'd0);
        r0   = rxRises;
        base = rxLog.size();
        csDown(MODE0);
        fork
            spiBits(MODE0, 16, 16'h4EA7, miso);
            begin
                cycles(20);
                loadTx(8'h22);
            end
        join
        csUp();
        checkOutput("b2b.miso", {16'd0, miso}, 32'h2211);
        checkOutput("b2b.rxPulses", rxRises - r0, 32'd2);
        checkOutput("b2b.rxFirst", (rxLog.size() > base) ? {24'd0, rxLog[base]} : 32'hDEAD, 32'hA7);
        checkOutput("b2b.rxSecond", (rxLog.size() > base + 1) ? {24'd0, rxLog[base+1]} : 32'hDEAD, 32'h4E);
        checkOutput("b2b.readyEnd", {31'd0, bus.o_tx_ready}, 32'd1);

        // Abort after five clocks, then a clean word.
        loadTx(8'h33);
        r0 = rxRises;
        csDown(MODE3);
        spiBits(MODE3, 5, 16'h001F, miso);
        csUp();
        checkOutput("abort.rxPulses", rxRises - r0, 32'd0);
        checkOutput("abort.rxByte", {24'd0, bus.o_rx_byte}, 32'h4E);
        checkOutput("abort.busy", {31'd0, bus.o_busy}, 32'd0);
        applyStimulus('{mode: MODE0, txByte: 8'h81, mosiByte: 8'h7E, flipMode: 1'b0, expMiso: 8'h81, expRx: 8'h7E}, "recover");

        // Asynchronous reset in the middle of bit 3.
        loadTx(8'h5D);
        csDown(MODE0);
        loadTx(8'h66);
        checkOutput("rst.readyFull", {31'd0, bus.o_tx_ready}, 32'd0);
        spiBits(MODE0, 3, 16'h0005, miso);
        cycles(4);
        #3;
        checkOutput("rst.preMiso", {31'd0, bus.o_miso}, 32'd1);
        checkOutput("rst.preBusy", {31'd0, bus.o_busy}, 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("rst.miso", {31'd0, bus.o_miso}, 32'd0);
        checkOutput("rst.ready", {31'd0, bus.o_tx_ready}, 32'd1);
        checkOutput("rst.rxByte", {24'd0, bus.o_rx_byte}, 32'd0);
        checkOutput("rst.rxValid", {31'd0, bus.o_rx_valid}, 32'd0);
        checkOutput("rst.busy", {31'd0, bus.o_busy}, 32'd0);
        cycles(3);
        rstN = 1'b1;
        r0 = rxRises;
        spiBits(MODE0, 5, 16'h001A, miso);
        checkOutput("rst.heldLowBusy", {31'd0, bus.o_busy}, 32'd0);
        checkOutput("rst.heldLowMiso", {16'd0, miso}, 32'd0);
        csUp();
        checkOutput("rst.noPulse", rxRises - r0, 32'd0);
        applyStimulus('{mode: MODE0, txByte: 8'hE7, mosiByte: 8'h18, flipMode: 1'b0, expMiso: 8'hE7, expRx: 8'h18}, "postRst");

        // Underrun: nothing loaded, so the word goes out as all ones.
        r0 = rxRises;
        v0 = validCycles;
        csDown(MODE1);
        spiBits(MODE1, 8, 16'h0012, miso);
        csUp();
        checkOutput("under.miso", {16'd0, miso}, 32'h00FF);
        checkOutput("under.rxByte", {24'd0, bus.o_rx_byte}, 32'h12);
        checkOutput("under.rxPulses", rxRises - r0, 32'd1);
        checkOutput("under.rxWidth", validCycles - v0, 32'd1);
`ifdef SPI_SUB_UNDERRUN_EN
        checkOutput("under.flagSet", {31'd0, bus.o_tx_underrun}, 32'd1);
        cycles(5);
        checkOutput("under.flagSticky", {31'd0, bus.o_tx_underrun}, 32'd1);
        loadTx(8'h44);
        checkOutput("under.flagClear", {31'd0, bus.o_tx_underrun}, 32'd0);
`else
        loadTx(8'h44);
`endif
        checkOutput("under.readyAfterLoad", {31'd0, bus.o_tx_ready}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
